// File: rtl/mac_share_arbiter_if.sv
// Bundle between the requesters / shared MAC unit and the arbiter.
// Operands and results are Q8.8 carried as raw 16-bit words; the arbiter never does arithmetic on them.
`default_nettype none

interface mac_share_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAC_DEPTH = 9
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  // Requester side
  logic                                            arb_en;
  logic [NUM_REQ-1:0]                              req;
  logic [NUM_REQ-1:0][MAC_DEPTH-1:0][DATA_W-1:0]   req_a;
  logic [NUM_REQ-1:0][MAC_DEPTH-1:0][DATA_W-1:0]   req_b;
  logic [NUM_REQ-1:0]                              gnt;
  logic [NUM_REQ-1:0]                              rsp_valid;
  logic [DATA_W-1:0]                               rsp_data;

  // Shared MAC unit side
  logic                                            mac_enable;
  logic [MAC_DEPTH-1:0][DATA_W-1:0]                mac_a;
  logic [MAC_DEPTH-1:0][DATA_W-1:0]                mac_b;
  logic [DATA_W-1:0]                               mac_result;

  // Status
  logic                                            busy;
  logic [CNT_W-1:0]                                op_count;

  // Environment: requesters plus the MAC unit
  modport master (
    output arb_en, req, req_a, req_b, mac_result,
    input  gnt, rsp_valid, rsp_data, mac_enable, mac_a, mac_b, busy, op_count
  );

  // Arbiter
  modport slave (
    input  arb_en, req, req_a, req_b, mac_result,
    output gnt, rsp_valid, rsp_data, mac_enable, mac_a, mac_b, busy, op_count
  );
endinterface

`default_nettype wire

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter time-sharing one registered MAC unit among NUM_REQ requesters.
// One operation takes three cycles: IDLE (grant decision), ISSUE (operands at MAC), CAPTURE (result back).
`default_nettype none

module mac_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAC_DEPTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mac_share_arbiter_if.slave     bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [MAC_DEPTH-1:0][DATA_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
  logic [IDX_W-1:0]   last_g_q,    last_g_d;
  logic [NUM_REQ-1:0] gnt_q,       gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
  logic               mac_en_q,    mac_en_d;
  vec_t               mac_a_q,     mac_a_d;
  vec_t               mac_b_q,     mac_b_d;
  logic               busy_q,      busy_d;
  logic [CNT_W-1:0]   op_cnt_q,    op_cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        rr_cand;

  // Round-robin pick: first requesting index searching upward from last_g+1, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_cand = (32'(last_g_q) + i) % NUM_REQ;
      if (!pick_found && bus.req[IDX_W'(rr_cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(rr_cand);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_g_d    = last_g_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    mac_en_d    = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    op_cnt_d    = op_cnt_q;

    unique case (state_q)
      IDLE: begin
        // req is only looked at here; arb_en gates nothing but this transition
        if (bus.arb_en && pick_found) begin
          state_d         = ISSUE;
          gnt_idx_d       = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          mac_en_d        = 1'b1;
          mac_a_d         = bus.req_a[pick_idx];
          mac_b_d         = bus.req_b[pick_idx];
        end
      end
      ISSUE: begin
        // MAC unit consumes operands this cycle; its result is ready next cycle
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d                = IDLE;
        rsp_data_d             = bus.mac_result;
        rsp_valid_d[gnt_idx_q] = 1'b1;
        last_g_d               = gnt_idx_q;
        op_cnt_d               = op_cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight operation without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      last_g_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      busy_q      <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      last_g_q    <= last_g_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      busy_q      <= busy_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.mac_enable = mac_en_q;
  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = op_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a behavioural registered MAC unit.
module tb_mac_share_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAC_DEPTH = 9;

  typedef logic [MAC_DEPTH-1:0][15:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mac_share_arbiter_if #(.NUM_REQ(NUM_REQ), .MAC_DEPTH(MAC_DEPTH)) bus_if ();

  mac_share_arbiter #(.NUM_REQ(NUM_REQ), .MAC_DEPTH(MAC_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Q8.8 dot product: Q16.16 accumulation, result taken back to Q8.8
  function automatic logic [15:0] mac_fn(input vec_t a, input vec_t b);
    logic signed [39:0] acc;
    logic signed [31:0] p;
    acc = '0;
    for (int k = 0; k < int'(MAC_DEPTH); k++) begin
      p   = $signed(a[k]) * $signed(b[k]);
      acc = acc + 40'(p);
    end
    return acc[23:8];
  endfunction

  // Shared MAC unit: result registered one cycle after mac_enable
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_if.mac_result <= '0;
    else if (bus_if.mac_enable) bus_if.mac_result <= mac_fn(bus_if.mac_a, bus_if.mac_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_ops(input int r, input logic [15:0] a, input logic [15:0] b);
    for (int k = 0; k < int'(MAC_DEPTH); k++) begin
      bus_if.req_a[r][k] = a;
      bus_if.req_b[r][k] = b;
    end
  endtask

  int          ord [5]     = '{0, 1, 2, 3, 0};
  logic [15:0] rr_exp [4]  = '{16'h0900, 16'h1200, 16'h1B00, 16'h2400};

  initial begin
    rst_n         = 1'b0;
    bus_if.arb_en = 1'b0;
    bus_if.req    = '0;
    bus_if.req_a  = '0;
    bus_if.req_b  = '0;
    tick();
    tick();

    // Reset values
    check("rst_gnt",      32'(bus_if.gnt),        32'h0);
    check("rst_rsp_vld",  32'(bus_if.rsp_valid),  32'h0);
    check("rst_mac_en",   32'(bus_if.mac_enable), 32'h0);
    check("rst_busy",     32'(bus_if.busy),       32'h0);
    check("rst_rsp_data", 32'(bus_if.rsp_data),   32'h0);
    check("rst_op_cnt",   32'(bus_if.op_count),   32'h0);
    check("rst_mac_a",    32'(|bus_if.mac_a),     32'h0);
    check("rst_mac_b",    32'(|bus_if.mac_b),     32'h0);

    // Request present while still in reset: no grant
    load_ops(0, 16'h0100, 16'h0200);
    bus_if.req    = 4'b0001;
    bus_if.arb_en = 1'b1;
    tick();
    check("rst_hold_gnt", 32'(bus_if.gnt), 32'h0);
    rst_n = 1'b1;

    // Single operation
    tick();
    check("t1_gnt",     32'(bus_if.gnt),        32'h1);
    check("t1_mac_en",  32'(bus_if.mac_enable), 32'h1);
    check("t1_busy",    32'(bus_if.busy),       32'h1);
    check("t1_mac_a0",  32'(bus_if.mac_a[0]),   32'h0100);
    check("t1_mac_b8",  32'(bus_if.mac_b[8]),   32'h0200);
    check("t1_rsp_c1",  32'(bus_if.rsp_valid),  32'h0);
    bus_if.req = '0;
    tick();
    check("t1_gnt_c2",  32'(bus_if.gnt),        32'h0);
    check("t1_mac_en2", 32'(bus_if.mac_enable), 32'h0);
    check("t1_busy_c2", 32'(bus_if.busy),       32'h1);
    tick();
    check("t1_rsp_vld", 32'(bus_if.rsp_valid),  32'h1);
    check("t1_rsp",     32'(bus_if.rsp_data),   32'h1200);
    check("t1_op_cnt",  32'(bus_if.op_count),   32'h1);
    check("t1_busy_c3", 32'(bus_if.busy),       32'h0);
    tick();
    check("t1_rsp_end", 32'(bus_if.rsp_valid),  32'h0);
    check("t1_rsp_hld", 32'(bus_if.rsp_data),   32'h1200);
    check("t1_mac_hld", 32'(bus_if.mac_a[4]),   32'h0100);

    // Round-robin wrap from fresh reset, all requesting
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t2_op_clr", 32'(bus_if.op_count), 32'h0);
    for (int r = 0; r < int'(NUM_REQ); r++) load_ops(r, 16'((r + 1) * 256), 16'h0100);
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t2_gnt%0d", k), 32'(bus_if.gnt), 32'(1) << ord[k]);
      if (k == 4) bus_if.req = '0;
      tick();
      check($sformatf("t2_gap%0d", k), 32'({bus_if.gnt, bus_if.rsp_valid}), 32'h0);
      tick();
      check($sformatf("t2_vld%0d", k), 32'(bus_if.rsp_valid), 32'(1) << ord[k]);
      check($sformatf("t2_dat%0d", k), 32'(bus_if.rsp_data), 32'(rr_exp[ord[k]]));
    end
    check("t2_op_cnt", 32'(bus_if.op_count), 32'h5);

    // Priority rotation: last grant 2, then 0101 -> 0 then 2
    bus_if.req = 4'b0100;
    tick();
    check("t3_gnt_a", 32'(bus_if.gnt), 32'h4);
    bus_if.req = '0;
    tick();
    tick();
    check("t3_vld_a", 32'(bus_if.rsp_valid), 32'h4);
    bus_if.req = 4'b0101;
    tick();
    check("t3_gnt_b", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0100;
    tick();
    tick();
    check("t3_vld_b", 32'(bus_if.rsp_valid), 32'h1);
    check("t3_dat_b", 32'(bus_if.rsp_data),  32'h0900);
    tick();
    check("t3_gnt_c", 32'(bus_if.gnt), 32'h4);
    bus_if.req = '0;
    tick();
    tick();
    check("t3_vld_c", 32'(bus_if.rsp_valid), 32'h4);
    check("t3_op_cnt", 32'(bus_if.op_count), 32'h8);

    // Enable gating
    bus_if.arb_en = 1'b0;
    bus_if.req    = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_blk_gnt%0d", k),  32'(bus_if.gnt),  32'h0);
      check($sformatf("t4_blk_busy%0d", k), 32'(bus_if.busy), 32'h0);
    end
    bus_if.arb_en = 1'b1;
    tick();
    check("t4_gnt", 32'(bus_if.gnt), 32'h2);
    bus_if.req    = '0;
    bus_if.arb_en = 1'b0;
    tick();
    check("t4_busy", 32'(bus_if.busy), 32'h1);
    tick();
    check("t4_vld",    32'(bus_if.rsp_valid), 32'h2);
    check("t4_dat",    32'(bus_if.rsp_data),  32'h1200);
    check("t4_op_cnt", 32'(bus_if.op_count),  32'h9);
    bus_if.arb_en = 1'b1;

    // Reset pulsed during CAPTURE
    bus_if.req = 4'b0001;
    tick();
    check("t5_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.req = '0;
    tick();
    check("t5_busy_cap", 32'(bus_if.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_async_cnt",  32'(bus_if.op_count), 32'h0);
    check("t5_async_busy", 32'(bus_if.busy),     32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_vld",  32'(bus_if.rsp_valid), 32'h0);
    check("t5_cnt",  32'(bus_if.op_count),  32'h0);
    check("t5_dat",  32'(bus_if.rsp_data),  32'h0);
    check("t5_busy", 32'(bus_if.busy),      32'h0);
    check("t5_gnt2", 32'(bus_if.gnt),       32'h0);
    tick();
    check("t5_vld2", 32'(bus_if.rsp_valid), 32'h0);

    // Counter wrap 0xFFFF -> 0x0000
    force dut.op_cnt_q = 16'hFFFF;
    tick();
    release dut.op_cnt_q;
    tick();
    check("t6_preset", 32'(bus_if.op_count), 32'hFFFF);
    bus_if.req = 4'b0001;
    tick();
    check("t6_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.req = '0;
    tick();
    tick();
    check("t6_vld",  32'(bus_if.rsp_valid), 32'h1);
    check("t6_dat",  32'(bus_if.rsp_data),  32'h0900);
    check("t6_wrap", 32'(bus_if.op_count),  32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one MAC unit (2..8).
REQ-002 Parameter MAC_DEPTH, default 9, SHALL set the operand vector length forwarded to the MAC unit.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 arb_en  input  1  SHALL permit new grants when high.
REQ-006 req  input  [NUM_REQ]  SHALL carry the per-requester operation request level.
REQ-007 req_a  input  [NUM_REQ][MAC_DEPTH] x 16 signed  SHALL carry the A operands in Q8.8, one vector per requester.
REQ-008 req_b  input  [NUM_REQ][MAC_DEPTH] x 16 signed  SHALL carry the B operands in Q8.8, one vector per requester.
REQ-009 gnt  output  [NUM_REQ]  SHALL be a one-hot, 1-cycle pulse meaning "operands captured".
REQ-010 rsp_valid  output  [NUM_REQ]  SHALL be a one-hot, 1-cycle pulse qualifying rsp_data for the owning requester.
REQ-011 rsp_data  output  16 signed  SHALL carry the MAC result in Q8.8.
REQ-012 mac_enable  output  1  SHALL be the 1-cycle enable pulse to the shared MAC unit.
REQ-013 mac_a, mac_b  output  [MAC_DEPTH] x 16 signed  SHALL be registered operand vectors to the MAC unit.
REQ-014 mac_result  input  16 signed  SHALL be the MAC unit's registered output, valid 1 cycle after mac_enable.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-016 op_count  output  16  SHALL hold the count of completed operations.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and CAPTURE.
REQ-018 The IDLE exit condition SHALL be: IDLE with arb_en=1 and any req bit set -> ISSUE.
  - grant index g: first set req bit searching upward from (last_g+1) mod NUM_REQ, wrapping around.
  - on that edge: mac_a<=req_a[g], mac_b<=req_b[g], gnt[g]<=1, mac_enable<=1.
REQ-019 The ISSUE state SHALL behave as follows:
  - outputs during the cycle: mac_enable=1 and gnt[g]=1.
  - on the next edge: mac_enable<=0, gnt<=0, state<=CAPTURE.
REQ-020 The CAPTURE state SHALL behave as follows:
  - data: rsp_data<=mac_result, rsp_valid[g]<=1, last_g<=g.
  - bookkeeping: op_count<=op_count+1, wrapping 0xFFFF->0x0000.
  - next state: IDLE.
REQ-021 Latency SHALL be fixed:
  - request seen in IDLE at cycle 0 -> gnt[g] high in cycle 1 -> rsp_valid[g] high in cycle 3.
  - a new grant MAY issue in cycle 3, giving throughput of 1 operation per 3 cycles.
REQ-022 req SHALL be sampled only in IDLE.
  - a requester SHALL hold req and operands stable until gnt and SHALL drop req by the cycle after gnt.
  - a req bit still high in the next IDLE SHALL be treated as a new request.
REQ-023 Fairness: with all requesters continuously requesting, each SHALL be granted exactly once per NUM_REQ grants, and no requester SHALL wait more than NUM_REQ-1 grants.
REQ-024 arb_en=0 SHALL block only the IDLE->ISSUE transition; an operation in flight SHALL complete normally.
REQ-025 rsp_data SHALL hold its value between rsp_valid pulses.
REQ-026 mac_a and mac_b SHALL hold their values until the next grant.
REQ-027 At most one gnt bit and one rsp_valid bit SHALL be high in any cycle, and gnt and rsp_valid SHALL never be high in the same cycle.
REQ-028 No arithmetic SHALL be performed on operands; op_count SHALL be unsigned.

Reset
REQ-029 rst_n low SHALL immediately force the following values:
  - state=IDLE; gnt=0, rsp_valid=0, mac_enable=0, busy=0.
  - rsp_data=0, mac_a/mac_b all 0, op_count=0.
  - last_g=NUM_REQ-1, so requester 0 has first priority.
REQ-030 Reset asserted mid-operation SHALL abort the operation silently: no rsp_valid pulse, and op_count not incremented.
REQ-031 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-032 Single operation:
  - stimulus: req[0]=1, req_a[0] all 0x0100, req_b[0] all 0x0200, MAC_DEPTH=9.
  - response: gnt[0] in cycle 1; rsp_valid[0] in cycle 3 with rsp_data=0x1200; op_count=1.
REQ-033 Round-robin wrap:
  - stimulus: req=4'b1111 held high.
  - response: grant order 0,1,2,3,0, with gnt spaced 3 cycles apart.
REQ-034 Priority rotation:
  - stimulus: last grant was 2, then req=4'b0101.
  - response: requester 0 is granted (wrap past 3), followed by requester 2.
REQ-035 Enable gating:
  - stimulus: arb_en=0 with req[1]=1.
  - response: no gnt and busy=0; after arb_en rises, gnt[1] follows 1 cycle later.
  - stimulus: arb_en dropped during ISSUE.
  - response: rsp_valid still pulses.
REQ-036 Reset mid-operation:
  - stimulus: rst_n pulsed low during CAPTURE.
  - response: rsp_valid stays 0; op_count=0, rsp_data=0, state=IDLE.
REQ-037 Counter wrap:
  - stimulus: op_count forced to 0xFFFF, then one completed operation.
  - response: op_count=0x0000.
